// File: rtl/bd_horn_encoder.sv
// Host-to-BD encoder: one {leaf code, payload} in, one or more 21-bit {route | chunk} BD words out.
// Optional error counter built only when BD_HORN_ENCODER_ERR_COUNT_EN is defined.
module bd_horn_encoder #(
   parameter int NBDin    = 21,
   parameter int Npayload = 48,
   parameter int Ncode    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [Ncode-1:0]    in_leaf_code,
   input  logic [Npayload-1:0] in_payload,
   input  logic                in_v,
   output logic                in_a,
   output logic [NBDin-1:0]    out_d,
   output logic                out_v,
   input  logic                out_a,
   output logic                invalid_drop,
   output logic [15:0]         err_count
);

   typedef enum logic {IDLE, SEND} state_t;

   typedef struct packed {
      logic [NBDin-1:0] route;
      logic [1:0]       words;
      logic [4:0]       w;
   } leaf_t;

   // Route pre-shifted to the MSBs so the chunk can simply be OR-ed below it.
   function automatic leaf_t leaf_info(input logic [2:0] code);
      leaf_t l;
      l = '0;
      case (code)
         3'd0: begin l.route = 21'h000000; l.words = 2'd1; l.w = 5'd20; end
         3'd1: begin l.route = 21'h100000; l.words = 2'd1; l.w = 5'd18; end
         3'd2: begin l.route = 21'h140000; l.words = 2'd2; l.w = 5'd17; end
         3'd3: begin l.route = 21'h160000; l.words = 2'd1; l.w = 5'd17; end
         3'd4: begin l.route = 21'h180000; l.words = 2'd3; l.w = 5'd16; end
         3'd5: begin l.route = 21'h190000; l.words = 2'd3; l.w = 5'd16; end
         3'd6: begin l.route = 21'h1A0000; l.words = 2'd1; l.w = 5'd17; end
         default: begin l.route = 21'h1C0000; l.words = 2'd1; l.w = 5'd17; end
      endcase
      return l;
   endfunction

   state_t                state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic                  rdy_q;
   logic                  drop_q;
   logic [2:0]            code_q;
   logic [Npayload-1:0]   payload_q;
   logic                  load;
   logic                  in_hs;
   logic                  code_ok;
   logic                  last;
   leaf_t                 lq;
   logic [5:0]            shamt;
   logic [NBDin-1:0]      chunk;
   logic [NBDin-1:0]      mask;

   assign in_hs   = in_v & in_a;
   assign code_ok = ~|in_leaf_code[Ncode-1:3];
   assign lq      = leaf_info(code_q);
   assign last    = (idx_q == lq.words - 2'd1);
   assign shamt   = 6'(idx_q) * 6'(lq.w);
   assign chunk   = NBDin'(payload_q >> shamt);
   assign mask    = (NBDin'(1) << lq.w) - NBDin'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         rdy_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rdy_q   <= 1'b1;
         drop_q  <= in_hs & ~code_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         code_q    <= in_leaf_code[2:0];
         payload_q <= in_payload;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load    = 1'b0;
      in_a    = 1'b0;
      out_v   = 1'b0;
      out_d   = '0;
      case (state_q)
         IDLE: begin
            in_a = rdy_q;
            if (in_v && rdy_q && code_ok) begin
               load    = 1'b1;
               idx_d   = 2'd0;
               state_d = SEND;
            end
         end
         SEND: begin
            out_v = 1'b1;
            out_d = lq.route | (chunk & mask);
            if (out_a) begin
               if (last) begin
                  // Last word frees the input in the same cycle so single-word leaves stream back to back.
                  in_a  = 1'b1;
                  idx_d = 2'd0;
                  if (in_v && code_ok) load = 1'b1;
                  else                 state_d = IDLE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign invalid_drop = drop_q;

`ifdef BD_HORN_ENCODER_ERR_COUNT_EN
   leaf_t       li;
   logic [5:0]  limit;
   logic        excess;
   logic [15:0] err_q;

   assign li     = leaf_info(in_leaf_code[2:0]);
   assign limit  = 6'(li.words) * 6'(li.w);
   assign excess = |(in_payload >> limit);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err_q <= 16'd0;
      else if (in_hs && (!code_ok || excess) && err_q != 16'hFFFF)
         err_q <= err_q + 16'd1;
   end

   assign err_count = err_q;
`else
   assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_bd_horn_encoder.sv
// Directed-vector bench for bd_horn_encoder; expected words are hand-derived from the leaf table.
module tb_bd_horn_encoder;

   logic        clk;
   logic        reset;
   logic [3:0]  in_leaf_code;
   logic [47:0] in_payload;
   logic        in_v;
   logic        in_a;
   logic [20:0] out_d;
   logic        out_v;
   logic        out_a;
   logic        invalid_drop;
   logic [15:0] err_count;

   int checks = 0;
   int errors = 0;

`ifdef BD_HORN_ENCODER_ERR_COUNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   bd_horn_encoder dut (
      .clk          (clk),
      .reset        (reset),
      .in_leaf_code (in_leaf_code),
      .in_payload   (in_payload),
      .in_v         (in_v),
      .in_a         (in_a),
      .out_d        (out_d),
      .out_v        (out_v),
      .out_a        (out_a),
      .invalid_drop (invalid_drop),
      .err_count    (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance to just after the falling edge: inputs change and outputs are sampled here.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] code, input logic [47:0] pl);
      in_leaf_code = code;
      in_payload   = pl;
      in_v         = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   logic [20:0] t3_exp [3];

   initial begin
      t3_exp[0] = 21'h180001;
      t3_exp[1] = 21'h180002;
      t3_exp[2] = 21'h180003;
      reset = 1'b0; in_v = 1'b0; out_a = 1'b0; in_leaf_code = '0; in_payload = '0;
      repeat (3) step();
      chk("rst_out_v", out_v, 0);
      chk("rst_out_d", out_d, 0);
      chk("rst_in_a", in_a, 0);
      chk("rst_drop", invalid_drop, 0);
      chk("rst_err", err_count, 0);
      reset = 1'b1;
      #1 chk("rel_in_a_low", in_a, 0);
      step();
      chk("rel_in_a", in_a, 1);

      // Single-word RI leaf
      out_a = 1'b1;
      drive(4'd0, 48'h0ABCDE);
      #1 chk("t1_accept", in_a, 1);
      step(); in_v = 1'b0; #1;
      chk("t1_out_v", out_v, 1);
      chk("t1_out_d", out_d, 21'h0ABCDE);
      chk("t1_in_a_last", in_a, 1);
      step();
      chk("t1_idle", out_v, 0);

      // Two-word PROG_AMMM
      drive(4'd2, (48'h1ABCD << 17) | 48'h00123);
      #1 chk("t2_accept", in_a, 1);
      step(); in_v = 1'b0; #1;
      chk("t2_w0", out_d, 21'h140123);
      chk("t2_in_a_w0", in_a, 0);
      step();
      chk("t2_w1", out_d, 21'h15ABCD);
      chk("t2_in_a_w1", in_a, 1);
      step();
      chk("t2_idle", out_v, 0);

      // Three-word PROG_TAT0 with 5-cycle stalls before each word
      out_a = 1'b0;
      drive(4'd4, 48'h0003_0002_0001);
      #1 chk("t3_accept", in_a, 1);
      step(); in_v = 1'b0;
      for (int w = 0; w < 3; w++) begin
         for (int s = 0; s < 5; s++) begin
            #1;
            chk("t3_stall_v", out_v, 1);
            chk("t3_stall_d", out_d, t3_exp[w]);
            chk("t3_stall_in_a", in_a, 0);
            step();
         end
         out_a = 1'b1;
         #1;
         chk("t3_word", out_d, t3_exp[w]);
         chk("t3_in_a", in_a, (w == 2) ? 1 : 0);
         step();
         out_a = 1'b0;
      end
      #1 chk("t3_idle", out_v, 0);

      // Invalid code then NEURON_CONFIG with an out-of-range payload bit
      out_a = 1'b1;
      drive(4'd9, 48'h1);
      #1 chk("t4_accept", in_a, 1);
      step(); in_v = 1'b0; #1;
      chk("t4_no_out", out_v, 0);
      chk("t4_drop", invalid_drop, 1);
      chk("t4_err1", err_count, ERR_EN ? 1 : 0);
      step();
      chk("t4_drop_once", invalid_drop, 0);
      chk("t4_no_out2", out_v, 0);
      drive(4'd1, 48'h1 << 18);
      #1 chk("t4b_accept", in_a, 1);
      step(); in_v = 1'b0; #1;
      chk("t4b_out_v", out_v, 1);
      chk("t4b_out_d", out_d, 21'h100000);
      chk("t4b_err2", err_count, ERR_EN ? 2 : 0);
      step();
      chk("t4b_idle", out_v, 0);

      // Back-to-back single-word inputs
      drive(4'd0, 48'h00001);
      #1 chk("t5_accept", in_a, 1);
      step(); in_payload = 48'h00002; #1;
      chk("t5_v0", out_v, 1);
      chk("t5_d0", out_d, 21'h000001);
      chk("t5_in_a_last", in_a, 1);
      step(); in_v = 1'b0; #1;
      chk("t5_v1", out_v, 1);
      chk("t5_d1", out_d, 21'h000002);
      step();
      chk("t5_idle", out_v, 0);

      // Reset during word 2 of PROG_TAT1
      drive(4'd5, 48'h0003_0002_0001);
      step(); in_v = 1'b0; #1;
      chk("t6_w0", out_d, 21'h190001);
      step();
      chk("t6_w1", out_d, 21'h190002);
      reset = 1'b0;
      #1;
      chk("t6_async_v", out_v, 0);
      chk("t6_async_d", out_d, 0);
      chk("t6_async_in_a", in_a, 0);
      chk("t6_err", err_count, 0);
      step(); step();
      chk("t6_hold_v", out_v, 0);
      reset = 1'b1;
      #1 chk("t6_rel_in_a", in_a, 0);
      step();
      chk("t6_in_a", in_a, 1);
      chk("t6_no_resid", out_v, 0);
      step();
      chk("t6_no_resid2", out_v, 0);
      chk("t6_err_after", err_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
